// File: rtl/fp_i2f_pkg.sv
// rtl/fp_i2f_pkg.sv - shared float/int format types, rounding modes, status flags and width helpers
package fp_i2f_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP64 = 2'd1,
        FP16 = 2'd2,
        BF16 = 2'd3
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8  = 2'd0,
        INT16 = 2'd1,
        INT32 = 2'd2,
        INT64 = 2'd3
    } int_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } roundmode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } i2f_state_e;

    function automatic int exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            default: return 7;
        endcase
    endfunction

    function automatic int fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    function automatic int int_width(int_format_e fmt);
        case (fmt)
            INT8:    return 8;
            INT16:   return 16;
            INT32:   return 32;
            default: return 64;
        endcase
    endfunction

endpackage

// File: rtl/fp_i2f_if.sv
// rtl/fp_i2f_if.sv - request/result bundle between a requester and the int-to-float converter
interface fp_i2f_if #(
    parameter int INT_WIDTH = 32,
    parameter int FP_WIDTH  = 32
);
    import fp_i2f_pkg::*;

    logic                 start_i;
    logic [INT_WIDTH-1:0] a_i;
    logic                 signed_i;
    roundmode_e           rnd_i;
    logic                 busy_o;
    logic [FP_WIDTH-1:0]  result_o;
    status_t              flags_o;
    logic                 done_o;

    modport master (
        output start_i, a_i, signed_i, rnd_i,
        input  busy_o, result_o, flags_o, done_o
    );

    modport slave (
        input  start_i, a_i, signed_i, rnd_i,
        output busy_o, result_o, flags_o, done_o
    );

endinterface

// File: rtl/fp_i2f_lzc.sv
// rtl/fp_i2f_lzc.sv - combinational leading-zero counter; returns WIDTH for an all-zero input
module fp_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_i2f.sv
// rtl/fp_i2f.sv - multi-cycle integer-to-float converter: normalise, round, pack in separate cycles
module fp_i2f
    import fp_i2f_pkg::*;
#(
    parameter fp_format_e  FP_FORMAT  = FP32,
    parameter int_format_e INT_FORMAT = INT32
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    fp_i2f_if.slave io
);

    localparam int W    = int_width(INT_FORMAT);
    localparam int E    = exp_bits(FP_FORMAT);
    localparam int M    = man_bits(FP_FORMAT);
    localparam int FPW  = fp_width(FP_FORMAT);
    localparam int XW   = E + 2;
    localparam int LZW  = $clog2(W + 1);
    localparam int EXTW = W + M + 1;

    localparam logic [XW-1:0] BIAS    = XW'((1 << (E - 1)) - 1);
    localparam logic [XW-1:0] EXP_TOP = XW'(W - 1);
    localparam logic [XW-1:0] EXP_MAX = XW'((1 << E) - 1);

    i2f_state_e     r_state;
    logic [W-1:0]   r_mag;
    logic [W-1:0]   r_norm;
    logic           r_sign;
    roundmode_e     r_rnd;
    logic [XW-1:0]  r_exp;
    logic [M-1:0]   r_mant;
    logic           r_inexact;
    logic [FPW-1:0] r_result;
    status_t        r_flags;
    logic           r_done;
    logic           r_busy;

    logic           w_sign;
    logic [W-1:0]   w_mag;
    logic [LZW-1:0] w_lz;
    logic [EXTW-1:0] w_ext;
    logic [M-1:0]   w_mant;
    logic           w_g;
    logic           w_s;
    logic           w_up;
    logic [M:0]     w_sum;
    logic           w_zero;
    logic           w_of;
    logic           w_inf;
    logic [FPW-1:0] w_result;
    status_t        w_flags;

    assign w_sign = io.signed_i & io.a_i[W-1];
    assign w_mag  = w_sign ? (~io.a_i + W'(1)) : io.a_i;

    fp_lzc #(
        .WIDTH (W),
        .CNT_W (LZW)
    ) u_lzc (
        .i_data  (r_mag),
        .o_count (w_lz)
    );

    // Hidden bit dropped; two zero LSBs guarantee guard/sticky exist when W-1 < M.
    assign w_ext  = {r_norm[W-2:0], {(M + 2){1'b0}}};
    assign w_mant = w_ext[EXTW-1 -: M];
    assign w_g    = w_ext[EXTW-1-M];
    assign w_s    = |w_ext[EXTW-M-2:0];

    always_comb begin
        w_up = 1'b0;
        case (r_rnd)
            RNE:     w_up = w_g & (w_mant[0] | w_s);
            RTZ:     w_up = 1'b0;
            RDN:     w_up = r_sign & (w_g | w_s);
            RUP:     w_up = ~r_sign & (w_g | w_s);
            RMM:     w_up = w_g;
            default: w_up = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_mant} + {{M{1'b0}}, w_up};

    // A normalised non-zero magnitude always has its MSB set, so the top bit doubles as the zero test.
    assign w_zero = ~r_norm[W-1];
    assign w_of   = (r_exp >= EXP_MAX);
    assign w_inf  = (r_rnd == RNE) | (r_rnd == RMM) |
                    ((r_rnd == RUP) & ~r_sign) | ((r_rnd == RDN) & r_sign);

    always_comb begin
        w_result   = {r_sign, r_exp[E-1:0], r_mant};
        w_flags    = '0;
        w_flags.nx = r_inexact;
        if (w_zero) begin
            w_result = '0;
            w_flags  = '0;
        end else if (w_of) begin
            w_flags.of = 1'b1;
            w_flags.nx = 1'b1;
            if (w_inf) begin
                w_result = {r_sign, {E{1'b1}}, {M{1'b0}}};
            end else begin
                w_result = {r_sign, {(E - 1){1'b1}}, 1'b0, {M{1'b1}}};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_mag     <= '0;
            r_norm    <= '0;
            r_sign    <= 1'b0;
            r_rnd     <= RNE;
            r_exp     <= '0;
            r_mant    <= '0;
            r_inexact <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= io.start_i;
                    if (io.start_i) begin
                        r_mag   <= w_mag;
                        r_sign  <= w_sign;
                        r_rnd   <= io.rnd_i;
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_norm  <= r_mag << w_lz;
                    r_exp   <= BIAS + EXP_TOP - XW'(w_lz);
                    r_state <= ROUND;
                end
                ROUND: begin
                    r_mant    <= w_sum[M-1:0];
                    r_exp     <= r_exp + XW'(w_sum[M]);
                    r_inexact <= w_g | w_s;
                    r_state   <= DONE;
                end
                DONE: begin
                    r_result <= w_result;
                    r_flags  <= w_flags;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io.busy_o   = r_busy;
    assign io.result_o = r_result;
    assign io.flags_o  = r_flags;
    assign io.done_o   = r_done;

endmodule

// File: tb/tb_fp_i2f.sv
// tb/tb_fp_i2f.sv - scoreboard bench for fp_i2f (FP32/INT32 and FP16/INT32 instances)
module tb_fp_i2f;
    import fp_i2f_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_i2f_if #(.INT_WIDTH(32), .FP_WIDTH(32)) if32();
    fp_i2f_if #(.INT_WIDTH(32), .FP_WIDTH(16)) if16();

    fp_i2f #(.FP_FORMAT(FP32), .INT_FORMAT(INT32)) u_dut32 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (if32)
    );

    fp_i2f #(.FP_FORMAT(FP16), .INT_FORMAT(INT32)) u_dut16 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (if16)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          acc;
        string       name;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer arithmetic on the magnitude, rounding by remainder vs half-ulp.
    function automatic void ref_conv(input logic [31:0] a, input bit sgn, input roundmode_e rm,
                                     input int eb, input int mb,
                                     output logic [31:0] res, output logic [4:0] fl);
        longint unsigned mag, q, rem, half;
        bit neg, up, inx;
        int e, sh, bexp;
        neg = sgn && a[31];
        mag = neg ? ((64'd1 << 32) - {32'd0, a}) : {32'd0, a};
        res = '0;
        fl = '0;
        up = 1'b0;
        inx = 1'b0;
        if (mag == 0) return;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        if (e <= mb) begin
            q = mag << (mb - e);
        end else begin
            sh = e - mb;
            q = mag >> sh;
            rem = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            inx = (rem != 0);
            case (rm)
                RNE:     up = (rem > half) || ((rem == half) && q[0]);
                RTZ:     up = 1'b0;
                RDN:     up = neg && inx;
                RUP:     up = !neg && inx;
                default: up = (rem >= half);
            endcase
        end
        q = q + {63'd0, up};
        if (q == (64'd1 << (mb + 1))) begin
            q = q >> 1;
            e++;
        end
        bexp = e + (1 << (eb - 1)) - 1;
        if (bexp >= (1 << eb) - 1) begin
            fl = 5'b00101;
            if (rm == RNE || rm == RMM || (rm == RUP && !neg) || (rm == RDN && neg))
                res = (32'(neg) << (eb + mb)) | (((32'd1 << eb) - 1) << mb);
            else
                res = (32'(neg) << (eb + mb)) | (((32'd1 << eb) - 2) << mb) | ((32'd1 << mb) - 1);
        end else begin
            res = (32'(neg) << (eb + mb)) | (32'(bexp) << mb) | (32'(q) & ((32'd1 << mb) - 1));
            fl = {4'b0000, inx};
        end
    endfunction

    task automatic check_done(input int which, input logic [31:0] res, input logic [4:0] fl);
        exp_t ex;
        tests++;
        if ((which == 0 && q32.size() == 0) || (which == 1 && q16.size() == 0)) begin
            fails++;
            $display("FAIL unexpected_done dut%0d: done_o with nothing outstanding, result=%h", which, res);
            return;
        end
        if (which == 0) ex = q32.pop_front();
        else            ex = q16.pop_front();
        if (res !== ex.res) begin
            fails++;
            $display("FAIL %s result dut%0d: got %h want %h", ex.name, which, res, ex.res);
        end
        tests++;
        if (fl !== ex.flags) begin
            fails++;
            $display("FAIL %s flags dut%0d: got %b want %b", ex.name, which, fl, ex.flags);
        end
        tests++;
        if (cyc - ex.acc != 3) begin
            fails++;
            $display("FAIL %s latency dut%0d: got %0d want 3", ex.name, which, cyc - ex.acc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && if32.done_o) check_done(0, if32.result_o, if32.flags_o);
        if (rst_n && if16.done_o) check_done(1, {16'd0, if16.result_o}, if16.flags_o);
    end

    task automatic issue(input int which, input logic [31:0] a, input bit sgn, input roundmode_e rm,
                         input logic [31:0] res, input logic [4:0] fl, input string name);
        exp_t ex;
        int n;
        logic bsy;
        n = 0;
        while (((which == 0) ? if32.busy_o : if16.busy_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL %s idle_wait dut%0d: busy_o stuck high for %0d cycles", name, which, n);
        end
        ex.res = res;
        ex.flags = fl;
        ex.acc = cyc + 1;
        ex.name = name;
        if (which == 0) begin
            if32.a_i = a; if32.signed_i = sgn; if32.rnd_i = rm; if32.start_i = 1'b1;
            q32.push_back(ex);
        end else begin
            if16.a_i = a; if16.signed_i = sgn; if16.rnd_i = rm; if16.start_i = 1'b1;
            q16.push_back(ex);
        end
        @(negedge clk);
        if32.start_i = 1'b0;
        if16.start_i = 1'b0;
        bsy = (which == 0) ? if32.busy_o : if16.busy_o;
        tests++;
        if (bsy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_after_accept dut%0d: got %b want 1", name, which, bsy);
        end
    endtask

    task automatic issue_model(input int which, input logic [31:0] a, input bit sgn, input roundmode_e rm,
                               input string name);
        logic [31:0] r;
        logic [4:0]  f;
        ref_conv(a, sgn, rm, (which == 0) ? 8 : 5, (which == 0) ? 23 : 10, r, f);
        issue(which, a, sgn, rm, r, f, name);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL %s drain: %0d/%0d results never arrived", name, q32.size(), q16.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests++;
        if (if32.result_o !== 32'd0 || if32.flags_o !== 5'd0 || if32.done_o !== 1'b0 || if32.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s dut0: result=%h flags=%b done=%b busy=%b want all 0", name,
                     if32.result_o, if32.flags_o, if32.done_o, if32.busy_o);
        end
        tests++;
        if (if16.result_o !== 16'd0 || if16.flags_o !== 5'd0 || if16.done_o !== 1'b0 || if16.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s dut1: result=%h flags=%b done=%b busy=%b want all 0", name,
                     if16.result_o, if16.flags_o, if16.done_o, if16.busy_o);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ex;
        logic [31:0] r;
        logic [4:0]  f;
        logic [31:0] a;
        if32.start_i = 1'b0; if32.a_i = '0; if32.signed_i = 1'b0; if32.rnd_i = RNE;
        if16.start_i = 1'b0; if16.a_i = '0; if16.signed_i = 1'b0; if16.rnd_i = RNE;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 32'h00000001, 1'b0, RNE, 32'h3F800000, 5'b00000, "one_u_rne");
        issue(0, 32'hFFFFFFFF, 1'b1, RNE, 32'hBF800000, 5'b00000, "minus_one");
        issue(0, 32'h80000000, 1'b1, RNE, 32'hCF000000, 5'b00000, "int_min");
        issue(0, 32'h01000001, 1'b0, RNE, 32'h4B800000, 5'b00001, "tie_rne");
        issue(0, 32'h01000001, 1'b0, RUP, 32'h4B800001, 5'b00001, "tie_rup");
        issue(0, 32'h01000001, 1'b0, RTZ, 32'h4B800000, 5'b00001, "tie_rtz");
        issue(0, 32'hFFFFFFFF, 1'b0, RNE, 32'h4F800000, 5'b00001, "umax_rne_carry");
        issue(0, 32'hFFFFFFFF, 1'b0, RTZ, 32'h4F7FFFFF, 5'b00001, "umax_rtz");
        issue(0, 32'h00000000, 1'b1, RDN, 32'h00000000, 5'b00000, "zero_rdn");
        issue(1, 32'h00010000, 1'b0, RNE, 32'h00007C00, 5'b00101, "fp16_of_rne");
        issue(1, 32'h00010000, 1'b0, RTZ, 32'h00007BFF, 5'b00101, "fp16_of_rtz");
        issue(1, 32'hFFFF0000, 1'b1, RDN, 32'h0000FC00, 5'b00101, "fp16_negof_rdn");
        issue(1, 32'h00000003, 1'b0, RNE, 32'h00004200, 5'b00000, "fp16_three");
        drain("directed");

        // Held start: accepts are expected at the accept edge and every 4th edge after it.
        a = 32'h00012345;
        ref_conv(a, 1'b0, RMM, 8, 23, r, f);
        ex.res = r; ex.flags = f; ex.name = "held_start";
        if32.a_i = a; if32.signed_i = 1'b0; if32.rnd_i = RMM; if32.start_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ex.acc = cyc + 1 + 4 * k;
            q32.push_back(ex);
        end
        repeat (9) @(negedge clk);
        if32.start_i = 1'b0;
        drain("held_start");

        // Reset while the request sits in ROUND: no done_o may follow.
        if32.a_i = 32'h12345678; if32.signed_i = 1'b0; if32.rnd_i = RNE; if32.start_i = 1'b1;
        @(negedge clk);
        if32.start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("reset_mid_round");
        repeat (6) @(negedge clk);
        issue(0, 32'h00000007, 1'b1, RNE, 32'h40E00000, 5'b00000, "after_reset");
        drain("after_reset");

        for (int i = 0; i < 150; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = ~a;
            issue_model(i % 2, a, 1'($urandom_range(0, 1)), roundmode_e'($urandom_range(0, 4)), "random");
        end
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
